// File: rtl/quad_updown_decoder_pkg.sv
// Shared constants for the quadrature up/down decoder: phase encodings,
// direction values and the next-phase helper used by the decode stage.
package quad_pkg;

  localparam int unsigned COUNT_W_DEF = 8;

  typedef enum logic [1:0] {
    PH0 = 2'b00,
    PH1 = 2'b10,
    PH2 = 2'b11,
    PH3 = 2'b01
  } phase_t;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  // Two edges fill the synchronizer and one more lets prev capture the
  // settled idle level, so none of these edges may count.
  localparam logic [1:0] STARTUP_EDGES = 2'd3;

  // Phase that follows ph when stepping up (A leads B).
  function automatic logic [1:0] next_up(input logic [1:0] ph);
    logic [1:0] nxt;
    nxt = PH0;
    case (ph)
      PH0:     nxt = PH1;
      PH1:     nxt = PH2;
      PH2:     nxt = PH3;
      default: nxt = PH0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/quad_updown_decoder_sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/quad_updown_decoder.sv
// Quadrature decoder: synchronizes A/B, compares against the previous pair
// and drives a wrapping position counter with step/wrap/err pulses.
module quad_updown_decoder
  import quad_pkg::*;
#(
  parameter int unsigned COUNT_W = COUNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               a_in,
  input  logic               b_in,
  input  logic               en,
  input  logic               clr,
  output logic [COUNT_W-1:0] count,
  output logic               dir,
  output logic               step,
  output logic               wrap,
  output logic               err
);

  logic       sa;
  logic       sb;
  logic [1:0] s;
  logic [1:0] prev;
  logic [1:0] start_cnt;
  logic       up_t;
  logic       dn_t;
  logic       bad_t;
  logic       warm;

  sync2 u_sync_a (.clk(clk), .rst(rst), .d(a_in), .q(sa));
  sync2 u_sync_b (.clk(clk), .rst(rst), .d(b_in), .q(sb));

  always_comb begin
    s     = {sa, sb};
    up_t  = (s == next_up(prev));
    dn_t  = (prev == next_up(s));
    bad_t = ((s ^ prev) == 2'b11);
    warm  = (start_cnt == STARTUP_EDGES);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev      <= '0;
      start_cnt <= '0;
      count     <= '0;
      dir       <= DIR_UP;
      step      <= 1'b0;
      wrap      <= 1'b0;
      err       <= 1'b0;
    end else begin
      prev <= s;
      step <= 1'b0;
      wrap <= 1'b0;
      err  <= 1'b0;
      if (!warm) begin
        start_cnt <= start_cnt + 2'd1;
      end else begin
        err <= bad_t;
        if (clr) begin
          count <= '0;
        end else if (en && up_t) begin
          count <= count + COUNT_W'(1);
          dir   <= DIR_UP;
          step  <= 1'b1;
          wrap  <= (count == '1);
        end else if (en && dn_t) begin
          count <= count - COUNT_W'(1);
          dir   <= DIR_DN;
          step  <= 1'b1;
          wrap  <= (count == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_quad_updown_decoder.sv
// Scoreboard bench for quad_updown_decoder: a phase-index/position model
// queues expected pulses; a monitor pops them when step or err fires.
module tb_quad_updown_decoder;

  localparam int unsigned CW   = 8;
  localparam int          MAXV = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_in = 1'b0;
  logic          b_in = 1'b0;
  logic          en = 1'b0;
  logic          clr = 1'b0;
  logic [CW-1:0] count;
  logic          dir;
  logic          step;
  logic          wrap;
  logic          err;

  always #5 clk = ~clk;

  quad_updown_decoder #(.COUNT_W(CW)) dut (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .en(en), .clr(clr),
    .count(count), .dir(dir), .step(step), .wrap(wrap), .err(err)
  );

  typedef struct {
    int   edge_no;
    logic is_err;
    int   cnt;
    logic dir;
    logic wrap;
  } exp_t;

  exp_t sbq[$];
  int   edge_no = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  // Reference model: position on the quadrature cycle and the counter value.
  logic [1:0] PHASES [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  int         m_idx = 0;
  int         m_cnt = 0;
  logic       m_dir = 1'b0;

  always @(posedge clk) edge_no++;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int idx_of(input logic [1:0] ab);
    int r = 0;
    for (int i = 0; i < 4; i++) if (PHASES[i] == ab) r = i;
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst && (step || err)) begin
      if (sbq.size() == 0) begin
        check("queue_depth_at_pulse", sbq.size(), 1);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("pulse_edge", edge_no, e.edge_no);
        check("pulse_err", int'(err), int'(e.is_err));
        check("pulse_step", int'(step), int'(!e.is_err));
        check("pulse_count", int'(count), e.cnt);
        check("pulse_dir", int'(dir), int'(e.dir));
        check("pulse_wrap", int'(wrap), int'(e.wrap));
      end
    end
    if (rst && wrap && !step) check("wrap_without_step", int'(wrap), 0);
  end

  // kind: 0 up, 1 down, 2 illegal (both phases flip), 3 idle
  task automatic do_step(input int kind, input logic en_v, input logic clr_v);
    exp_t e;
    logic w;
    @(negedge clk);
    en  = en_v;
    clr = clr_v;
    if (kind < 3) begin
      m_idx = (m_idx + ((kind == 0) ? 1 : (kind == 1) ? 3 : 2)) % 4;
      {a_in, b_in} = PHASES[m_idx];
    end
    if (clr_v) m_cnt = 0;
    if (kind == 2) begin
      e = '{edge_no + 3, 1'b1, m_cnt, m_dir, 1'b0};
      sbq.push_back(e);
    end else if (kind < 2 && en_v && !clr_v) begin
      w     = (kind == 0) ? (m_cnt == MAXV - 1) : (m_cnt == 0);
      m_cnt = (m_cnt + ((kind == 0) ? 1 : MAXV - 1)) % MAXV;
      m_dir = (kind == 1);
      e = '{edge_no + 3, 1'b0, m_cnt, m_dir, w};
      sbq.push_back(e);
    end
    repeat (3) @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic check_state(input string tag);
    repeat (4) @(negedge clk);
    check({tag, "_count"}, int'(count), m_cnt);
    check({tag, "_dir"}, int'(dir), int'(m_dir));
    check({tag, "_pending"}, sbq.size(), 0);
  endtask

  task automatic do_reset(input logic [1:0] ab);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check("async_reset_count", int'(count), 0);
    sbq.delete();
    {a_in, b_in} = ab;
    m_idx = idx_of(ab);
    m_cnt = 0;
    m_dir = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    en = 1'b1;
    // Idle level 11 at release must not register as a step or error.
    do_reset(2'b11);
    repeat (5) @(negedge clk);
    check("post_reset_step", int'(step), 0);
    check_state("startup_idle");

    for (int i = 0; i < 20; i++) do_step(0, 1'b1, 1'b0);
    check_state("up20");

    do_step(0, 1'b1, 1'b1);
    check_state("clr_with_step");
    do_step(0, 1'b1, 1'b0);
    do_step(0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) do_step(1, 1'b1, 1'b0);
    check_state("down_wrap");

    do_step(2, 1'b1, 1'b0);
    check_state("illegal");
    do_step(0, 1'b1, 1'b0);

    for (int i = 0; i < 4; i++) do_step(0, 1'b0, 1'b0);
    do_step(0, 1'b1, 1'b0);
    check_state("en_gate");
    do_step(0, 1'b1, 1'b0);
    do_step(1, 1'b1, 1'b1);
    check_state("clr_down");

    for (int i = 0; i < 37; i++) do_step(0, 1'b1, 1'b0);
    check_state("at37");
    // A step is left in flight so reset has to abort it.
    @(negedge clk);
    m_idx = (m_idx + 1) % 4;
    {a_in, b_in} = PHASES[m_idx];
    do_reset(PHASES[m_idx]);
    repeat (5) @(negedge clk);
    for (int i = 0; i < 3; i++) do_step(0, 1'b1, 1'b0);
    check_state("after_mid_reset");

    for (int i = 0; i < 80; i++) begin
      int r;
      r = $urandom_range(0, 9);
      do_step((r < 4) ? 0 : (r < 7) ? 1 : (r == 7) ? 2 : 3,
              ($urandom_range(0, 5) != 0), ($urandom_range(0, 11) == 0));
    end
    check_state("random");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    check("global_timeout", 1, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule
